// File: rtl/word16_serial_tx_pkg.sv
// Shared types and constants for the 16-bit serial transmit path.
package word16_serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 18;
    localparam int DATA_BITS  = 16;

    // Tick counter width; a one-clock bit period still needs a 1-bit register.
    function automatic int tick_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/word16_serial_tx_bit_period_tick.sv
// Bit-period timer: pulses tick on the last clock of each serial bit period.
module bit_period_tick
    import word16_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            W    = tick_width(CLKS_PER_BIT);
    localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr || !en || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/word16_serial_tx.sv
// Serial transmitter: captures a 16-bit word on handshake and sends
// start bit, 16 data bits and stop bit, each CLKS_PER_BIT clocks long.
module word16_serial_tx
    import word16_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit LSB_FIRST    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bitcnt;
    logic                 tick;
    logic                 accept;
    logic                 head;
    logic [DATA_BITS-1:0] shnext;

    assign accept = in_valid && in_ready;

    // The next bit to send always sits at the outgoing end of shreg.
    assign head   = LSB_FIRST ? shreg[0] : shreg[DATA_BITS-1];
    assign shnext = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

    bit_period_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (busy),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
            bitcnt   <= '0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= in_data;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        tx     <= head;
                        shreg  <= shnext;
                        bitcnt <= '0;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bitcnt == 4'(DATA_BITS - 1)) begin
                            tx     <= 1'b1;
                            bitcnt <= '0;
                            state  <= STOP;
                        end else begin
                            tx     <= head;
                            shreg  <= shnext;
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Frame ends here; in_ready rises with done so a held word goes next.
                    if (tick) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/word16_serial_tx.md
Name: word16_serial_tx

Overview:
Transmit side of the 16-bit word path. Accepts a 16-bit parallel word through a valid/ready handshake, captures it, and shifts it out on a single serial line as one frame: 1 start bit (0), 16 data bits, 1 stop bit (1). Each bit lasts a programmable number of clocks. Sits between the datapath's 16-bit register outputs and the serial link that the matching receiver samples.

Parameters:
CLKS_PER_BIT, 4, clocks per serial bit period; legal range ≥1.
LSB_FIRST, 1, 1 = data bit 0 sent first; 0 = bit 15 sent first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous reset, active-low; sampled on the clk rising edge.
in_data  input  16  word to transmit; sampled only on the accept edge.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  high exactly when state == IDLE.
tx  output  1  registered serial line; idles high.
busy  output  1  high in START, DATA and STOP.
done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, tx=1, busy=0, done=0, in_ready=1, bit counter=0, tick counter=0. Reset mid-frame aborts the frame with no done pulse. Line returns high on the next cycle.
- Accept occurs at edge k when in_valid && in_ready: capture in_data into the shift register, go to START, tx=0 from cycle k+1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: bit i (0..15 in send order) drives tx for cycles k+1+C(1+i) .. k+C(2+i), where C = CLKS_PER_BIT. Shift register shifts once per bit period.
- STOP: tx=1 for C cycles.
- At edge k+18C the block returns to IDLE and done=1 for that single cycle. in_ready is also 1 in that cycle.
- Frame length is exactly 18·C cycles from the accept edge to IDLE. Minimum back-to-back spacing is accept edges 18C+1 apart, because the IDLE cycle is mandatory.
- Tick counter counts 0..C-1, with width clog2(C) (minimum 1). With C=1, tick is every cycle and there is no counter wrap hazard.
- Bit counter counts 0..15 and is used only in DATA. Wrap from 15 moves the state to STOP.
- in_valid while busy: ignored, not accepted. The producer holds it until in_ready rises.
- in_data changes while busy: no effect on the frame in flight.
- done and in_valid in the same IDLE cycle: the new word is accepted at that edge.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), FRAME_BITS=18, DATA_BITS=16.
- One natural sub-module, bit_period_tick: counter with clk, rst_n and enable inputs. It emits a one-cycle tick when the count reaches CLKS_PER_BIT-1, then clears. It is cleared on accept so the start bit gets a full period.

Test Plan:
- Reset held low for 3 cycles mid-idle -> tx=1, in_ready=1, busy=0, done=0 in every cycle.
- C=4, LSB_FIRST=1, send 16'hA5C3 -> tx sampled at the middle of each period reads 0, 1,1,0,0,0,0,1,1, 1,0,1,0,0,1,0,1, 1. done pulses exactly 72 cycles after the accept edge.
- C=1, LSB_FIRST=0, send 16'h8001 -> tx = 0,1,0×14,1,1 on consecutive cycles. done is at the accept edge + 18.
- in_valid held high continuously with words 16'h0000 then 16'hFFFF -> the second accept occurs in the done/IDLE cycle. Both frames are bit-exact, with no lost or duplicated word.
- rst_n pulsed low at data bit 7 of 16'h1234 -> tx=1 on the next cycle, no done pulse. The next word 16'h00FF is transmitted correctly.
- in_data toggled randomly while busy during a 16'h5A5A frame -> serial output still encodes 16'h5A5A.
